// File: rtl/four_bit_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
// Other blocks reference the default width from here.
package four_bit_adder_pkg;

    localparam int ADDER_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/four_bit_adder_full_adder.sv
// One-bit full-adder cell; chained by the top level to form the ripple adder.
// Purely combinational.
module four_bit_adder_full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/four_bit_adder.sv
// Registered ripple-carry adder: {C_out,S} = A + B + C_in, one cycle latency.
// A valid flag travels with the result; invalid cycles hold the last sum.
module four_bit_adder
    import four_bit_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = C_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        four_bit_adder_full_adder u_fa (
            .a     (A[i]),
            .b     (B[i]),
            .c_in  (carry[i]),
            .s     (sum[i]),
            .c_out (carry[i+1])
        );
    end

    logic [WIDTH-1:0] s_d, s_q;
    logic             c_out_d, c_out_q;
    logic             valid_d, valid_q;

    always_comb begin
        s_d     = s_q;
        c_out_d = c_out_q;
        valid_d = in_valid;
        // Gate on in_valid so don't-care operands never reach the held result.
        if (in_valid) begin
            s_d     = sum;
            c_out_d = carry[WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= '0;
            c_out_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            c_out_q <= c_out_d;
            valid_q <= valid_d;
        end
    end

    assign S         = s_q;
    assign C_out     = c_out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_four_bit_adder.sv
// Self-checking bench for four_bit_adder: directed plan, exhaustive sweep,
// and randomized traffic against an arithmetic reference model.
module tb_four_bit_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] A, B;
    logic       C_in, in_valid;
    logic [3:0] S;
    logic       C_out, out_valid;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] m_s = '0;
    logic       m_c = 1'b0;
    logic       m_v = 1'b0;

    four_bit_adder #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .C_in      (C_in),
        .in_valid  (in_valid),
        .S         (S),
        .C_out     (C_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] es,
                         input logic ec, input logic ev);
        vectors++;
        assert (S === es && C_out === ec && out_valid === ev)
        else begin
            miscompares++;
            $error("FAIL %s: got S=%h C_out=%b out_valid=%b, want S=%h C_out=%b out_valid=%b",
                   tag, S, C_out, out_valid, es, ec, ev);
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [3:0] b,
                        input logic ci, input logic v);
        logic [4:0] total;
        @(negedge clk);
        A = a; B = b; C_in = ci; in_valid = v;
        @(posedge clk);
        #1;
        total = 5'(a) + 5'(b) + 5'(ci);
        if (v) begin
            m_s = total[3:0];
            m_c = total[4];
        end
        m_v = v;
    endtask

    initial begin
        rst = 1'b1;
        A = 4'hF; B = 4'hF; C_in = 1'b1; in_valid = 1'b1;
        #1;
        check("reset_immediate", 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_held", 4'h0, 1'b0, 1'b0);
        end
        rst = 1'b0;

        step(4'h0, 4'h0, 1'b0, 1'b1);
        check("first_after_reset", 4'h0, 1'b0, 1'b1);
        step(4'h0, 4'h1, 1'b0, 1'b1);
        check("0+1", 4'h1, 1'b0, 1'b1);
        step(4'h1, 4'h2, 1'b0, 1'b1);
        check("1+2", 4'h3, 1'b0, 1'b1);
        step(4'h5, 4'h3, 1'b1, 1'b1);
        check("5+3+1", 4'h9, 1'b0, 1'b1);
        step(4'hF, 4'hF, 1'b1, 1'b0);
        check("hold_invalid", 4'h9, 1'b0, 1'b0);
        step(4'hF, 4'h1, 1'b0, 1'b1);
        check("F+1_wrap", 4'h0, 1'b1, 1'b1);
        step(4'hF, 4'hF, 1'b1, 1'b1);
        check("max_sum", 4'hF, 1'b1, 1'b1);
        step(4'hA, 4'hA, 1'b1, 1'b1);
        check("A+A+1", 4'h5, 1'b1, 1'b1);

        #2 rst = 1'b1;
        #1;
        check("async_reset_midstream", 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
        m_s = '0; m_c = 1'b0; m_v = 1'b0;
        step(4'h2, 4'h2, 1'b0, 1'b1);
        check("2+2_after_reset", 4'h4, 1'b0, 1'b1);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] idx;
            idx = 9'(i);
            step(idx[3:0], idx[7:4], idx[8], 1'b1);
            check("exhaustive", m_s, m_c, m_v);
        end

        for (int i = 0; i < 300; i++) begin
            step(4'($urandom), 4'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0));
            check("random", m_s, m_c, m_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/four_bit_adder.md
Name: four_bit_adder

Overview:
- Registered 4-bit ripple-carry adder: S + C_out = A + B + C_in, captured on the rising clock edge.
- Datapath leaf used wherever a small carry-in/carry-out adder is required; built from a chain of 1-bit full-adder cells.
- Optional valid qualifier travels alongside the result so upstream and downstream logic can pipeline through it.

Parameters:
- WIDTH, 4, operand/sum width in bits. Values other than 4 are legal; all tests run at 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- C_in  input  1  carry into bit 0.
- in_valid  input  1  qualifies A/B/C_in this cycle.
- S  output  WIDTH  registered sum bits [WIDTH-1:0].
- C_out  output  1  registered carry out of bit WIDTH-1.
- out_valid  output  1  high when S/C_out hold a result captured from a valid input.

Behaviour:
- One clock, one asynchronous, active-high reset (clk, rst).
- While rst is high, S=0, C_out=0 and out_valid=0 immediately, independent of clk.
- Reset deassertion needs no synchronisation inside the block. The first capture occurs on the first rising edge with rst low.
- Combinational core:
  - WIDTH full-adder cells in ripple order.
  - Cell i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i.
  - c_0 = C_in; C_out = c_WIDTH.
- Arithmetic: {C_out,S} = A + B + C_in, an exact (WIDTH+1)-bit unsigned result.
  - No saturation.
  - Overflow shows only through C_out.
  - S wraps modulo 2^WIDTH.
- Latency: exactly 1 cycle. Inputs sampled at edge n appear on S/C_out/out_valid after edge n.
- in_valid=1 at an edge: S, C_out load the new sum; out_valid goes to 1.
- in_valid=0 at an edge: S, C_out hold their previous values; out_valid goes to 0.
- Throughput: one result per cycle. There is no back-pressure and no ready signal.
- Maximum sum is 2^(WIDTH+1)-1 (all ones plus C_in=1) and gives S=all ones, C_out=1. For WIDTH=4 this is 31 -> S=4'hF, C_out=1.
- Minimum sum is 0 and gives S=0, C_out=0.
- X/Z on A/B/C_in while in_valid=0 must not affect held outputs.
- Reset mid-stream:
  - An in-flight result is discarded and outputs go to 0.
  - The first edge after release with in_valid=1 produces a fresh result; nothing stale reappears.
- No internal state beyond the output registers.

Decomposition:
- Shared package: none required. Optional constant ADDER_WIDTH_DEFAULT=4 if other blocks reference it.
- Natural sub-module: full_adder (ports a, b, c_in, s, c_out; purely combinational). Instantiate WIDTH copies via a generate loop, carry chained bit 0 -> WIDTH-1.
- The top level holds only the generate chain and the output register/valid logic.

Test Plan:
- Reset, then inputs applied:
  - rst high with A=4'hF, B=4'hF, C_in=1, in_valid=1 -> S=0, C_out=0, out_valid=0 immediately and on every edge while rst is high.
  - rst released, then A=0, B=0, C_in=0, in_valid=1 -> after 1 edge S=4'h0, C_out=0, out_valid=1.
- Basic sums, one per cycle, in_valid=1:
  - A=0, B=1, C_in=0 -> S=1, C_out=0.
  - A=1, B=2, C_in=0 -> S=3, C_out=0.
  - A=5, B=3, C_in=1 -> S=9, C_out=0.
- Carry-out and wrap:
  - A=4'hF, B=1, C_in=0 -> S=4'h0, C_out=1.
  - A=4'hA, B=4'hA, C_in=1 -> S=4'h5, C_out=1.
  - A=4'hF, B=4'hF, C_in=1 -> S=4'hF, C_out=1.
- Hold: after A=5, B=3, C_in=1 (S=9), drop in_valid to 0 and change A=4'hF, B=4'hF -> S stays 9, C_out stays 0, out_valid=0.
- Async reset mid-stream: assert rst between edges while S=4'h5, C_out=1 -> outputs go to 0 before the next edge. Release, apply A=2, B=2, C_in=0 -> S=4, C_out=0 after 1 edge.
- Exhaustive: all 512 combinations of A, B, C_in back-to-back -> each {C_out,S} equals A+B+C_in one cycle later.
